// File: rtl/fft_pkg.sv
// Shared fixed-point helpers for the radix-2 FFT butterflies: Q-format limits,
// round-half-up with saturation, and a wide complex pair.
package fft_pkg;

   typedef struct packed {
      logic signed [63:0] re;
      logic signed [63:0] im;
   } cplx_t;

   // Largest and smallest Q1.(width-1) values, as wide signed constants.
   function automatic logic signed [63:0] tw_one(input int unsigned width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] tw_min(input int unsigned width);
      return -(64'sd1 <<< (width - 1));
   endfunction

   function automatic logic signed [63:0] sat_round(input logic signed [63:0] value,
                                                    input int unsigned shift,
                                                    input int unsigned width);
      logic signed [63:0] r;
      r = value;
      if (shift != 0)
         r = (value + (64'sd1 <<< (shift - 1))) >>> shift;
      if (r > tw_one(width))
         r = tw_one(width);
      else if (r < tw_min(width))
         r = tw_min(width);
      return r;
   endfunction

endpackage

// File: rtl/cplx_mul_rs.sv
// Two-register complex multiply: full-precision product, then round/saturate
// down to OW bits after an arithmetic right shift of SHIFT.
module cplx_mul_rs
   import fft_pkg::*;
#(
   parameter int unsigned DW    = 17,
   parameter int unsigned TW    = 16,
   parameter int unsigned OW    = 16,
   parameter int unsigned SHIFT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic signed [DW-1:0] d_re,
   input  logic signed [DW-1:0] d_im,
   input  logic signed [TW-1:0] w_re,
   input  logic signed [TW-1:0] w_im,
   output logic signed [OW-1:0] y_re,
   output logic signed [OW-1:0] y_im
);

   localparam int unsigned PW = DW + TW + 1;

   logic signed [PW-1:0] dx_re, dx_im, wx_re, wx_im;
   logic signed [PW-1:0] p_re, p_im;
   cplx_t                p_wide;

   always_comb begin
      dx_re    = PW'(d_re);
      dx_im    = PW'(d_im);
      wx_re    = PW'(w_re);
      wx_im    = PW'(w_im);
      p_wide.re = 64'(p_re);
      p_wide.im = 64'(p_im);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_re <= '0;
         p_im <= '0;
         y_re <= '0;
         y_im <= '0;
      end else if (en) begin
         p_re <= dx_re * wx_re - dx_im * wx_im;
         p_im <= dx_re * wx_im + dx_im * wx_re;
         y_re <= OW'(sat_round(p_wide.re, SHIFT, OW));
         y_im <= OW'(sat_round(p_wide.im, SHIFT, OW));
      end
   end

endmodule

// File: rtl/butterfly_dif.sv
// Radix-2 DIF butterfly: y0 = a + b, y1 = (a - b) * w (conjugate w when inv),
// three-stage pipeline with a single global enable driven by the output stage.
module butterfly_dif
   import fft_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SCALE = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    inv,
   input  logic signed [WIDTH-1:0] a_re,
   input  logic signed [WIDTH-1:0] a_im,
   input  logic signed [WIDTH-1:0] b_re,
   input  logic signed [WIDTH-1:0] b_im,
   input  logic signed [WIDTH-1:0] twiddle_re,
   input  logic signed [WIDTH-1:0] twiddle_im,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] y0_re,
   output logic signed [WIDTH-1:0] y0_im,
   output logic signed [WIDTH-1:0] y1_re,
   output logic signed [WIDTH-1:0] y1_im
);

   localparam int unsigned SW = WIDTH + 1;
   localparam logic signed [WIDTH-1:0] W_ONE = WIDTH'(tw_one(WIDTH));
   localparam logic signed [WIDTH-1:0] W_MIN = WIDTH'(tw_min(WIDTH));

   logic                    en, accept, rst_done, v1, v2;
   logic signed [WIDTH-1:0] w_im_eff;
   logic signed [SW-1:0]    s1_sum_re, s1_sum_im, s1_d_re, s1_d_im;
   logic signed [SW-1:0]    s2_sum_re, s2_sum_im;
   logic signed [WIDTH-1:0] s1_w_re, s1_w_im;

   // rst_done keeps in_ready low through reset and for the first edge after it.
   assign en       = !out_valid || out_ready;
   assign in_ready = rst_done && en;
   assign accept   = in_valid && in_ready;

   always_comb begin
      w_im_eff = twiddle_im;
      if (inv)
         w_im_eff = (twiddle_im == W_MIN) ? W_ONE : -twiddle_im;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_done  <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         s1_sum_re <= '0;
         s1_sum_im <= '0;
         s1_d_re   <= '0;
         s1_d_im   <= '0;
         s1_w_re   <= '0;
         s1_w_im   <= '0;
         s2_sum_re <= '0;
         s2_sum_im <= '0;
         y0_re     <= '0;
         y0_im     <= '0;
      end else begin
         rst_done <= 1'b1;
         if (en) begin
            v1        <= accept;
            v2        <= v1;
            out_valid <= v2;
            if (accept) begin
               s1_sum_re <= SW'(a_re) + SW'(b_re);
               s1_sum_im <= SW'(a_im) + SW'(b_im);
               s1_d_re   <= SW'(a_re) - SW'(b_re);
               s1_d_im   <= SW'(a_im) - SW'(b_im);
               s1_w_re   <= twiddle_re;
               s1_w_im   <= w_im_eff;
            end
            s2_sum_re <= s1_sum_re;
            s2_sum_im <= s1_sum_im;
            y0_re     <= WIDTH'(sat_round(64'(s2_sum_re), SCALE, WIDTH));
            y0_im     <= WIDTH'(sat_round(64'(s2_sum_im), SCALE, WIDTH));
         end
      end
   end

   cplx_mul_rs #(
      .DW    (SW),
      .TW    (WIDTH),
      .OW    (WIDTH),
      .SHIFT (WIDTH - 1 + SCALE)
   ) u_mul (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .d_re (s1_d_re),
      .d_im (s1_d_im),
      .w_re (s1_w_re),
      .w_im (s1_w_im),
      .y_re (y1_re),
      .y_im (y1_im)
   );

endmodule

// File: tb/tb_butterfly_dif.sv
// Directed and random checks of butterfly_dif, with SCALE=0 and SCALE=1 copies
// driven in lockstep and compared against a scoreboard of expected results.
module tb_butterfly_dif;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, inv, out_ready;
   logic in_ready, in_ready_s1, out_valid, out_valid_s1;
   logic signed [W-1:0] a_re, a_im, b_re, b_im, tw_re, tw_im;
   logic signed [W-1:0] y0r, y0i, y1r, y1i;
   logic signed [W-1:0] z0r, z0i, z1r, z1i;

   typedef struct {
      int   ar, ai, br, bi, wr, wi;
      bit   inv;
      bit   hand0, hand1;
      logic [63:0] h0, h1;
   } beat_t;

   typedef struct {
      logic [63:0] e0, e1;
      int          acc;
   } exp_t;

   beat_t beats[$];
   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc_cnt  = 0;
   bit    lat_on   = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   butterfly_dif #(.WIDTH(W), .SCALE(0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .twiddle_re(tw_re), .twiddle_im(tw_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .y0_re(y0r), .y0_im(y0i), .y1_re(y1r), .y1_im(y1i));

   butterfly_dif #(.WIDTH(W), .SCALE(1)) u_dut_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s1), .inv(inv),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .twiddle_re(tw_re), .twiddle_im(tw_im),
      .out_valid(out_valid_s1), .out_ready(out_ready),
      .y0_re(z0r), .y0_im(z0i), .y1_re(z1r), .y1_im(z1i));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack4(input int p, input int q, input int r, input int s);
      return {16'(p), 16'(q), 16'(r), 16'(s)};
   endfunction

   function automatic int rnd_sat(input longint v, input int sh);
      real    q;
      longint r;
      q = real'(v) / (2.0 ** sh);
      r = longint'($floor(q + 0.5));
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
   endfunction

   function automatic logic [63:0] model(input beat_t bt, input int scale);
      longint sr, si, dr, di, wr, wi, pr, pi;
      sr = bt.ar + bt.br;
      si = bt.ai + bt.bi;
      dr = bt.ar - bt.br;
      di = bt.ai - bt.bi;
      wr = bt.wr;
      wi = bt.wi;
      if (bt.inv) wi = (bt.wi == -32768) ? 32767 : -bt.wi;
      pr = dr * wr - di * wi;
      pi = dr * wi + di * wr;
      return pack4(rnd_sat(sr, scale), rnd_sat(si, scale),
                   rnd_sat(pr, 15 + scale), rnd_sat(pi, 15 + scale));
   endfunction

   function automatic beat_t mk(input int ar, input int ai, input int br, input int bi,
                                input int wr, input int wi, input bit iv);
      beat_t b;
      b.ar = ar; b.ai = ai; b.br = br; b.bi = bi; b.wr = wr; b.wi = wi; b.inv = iv;
      b.hand0 = 1'b0; b.hand1 = 1'b0; b.h0 = '0; b.h1 = '0;
      return b;
   endfunction

   task automatic apply(input beat_t b);
      a_re = W'(b.ar); a_im = W'(b.ai); b_re = W'(b.br); b_im = W'(b.bi);
      tw_re = W'(b.wr); tw_im = W'(b.wi); inv = b.inv;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 64'(out_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("y_scale0", {y0r, y0i, y1r, y1i}, e.e0);
            check("y_scale1", {z0r, z0i, z1r, z1i}, e.e1);
            if (lat_on) check("latency", 64'(cyc_cnt + 1 - e.acc), 64'd3);
         end
      end
   end

   task automatic run_stream(input bit stall);
      int          idx = 0;
      int          cyc = 0;
      int          stall_left = stall ? 5 : 0;
      bit          stalling = 1'b0;
      logic [63:0] snap0 = '0, snap1 = '0;
      exp_t        e;
      while ((idx < beats.size() || exp_q.size() != 0) && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
         if (stall && !stalling && stall_left > 0 && out_valid) begin
            stalling = 1'b1;
            snap0 = {y0r, y0i, y1r, y1i};
            snap1 = {z0r, z0i, z1r, z1i};
         end
         if (stalling && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         if (idx < beats.size()) begin
            apply(beats[idx]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (!out_ready) begin
            check("stall_in_ready", 64'({in_ready, in_ready_s1}), 64'd0);
            check("stall_hold_s0", {y0r, y0i, y1r, y1i}, snap0);
            check("stall_hold_s1", {z0r, z0i, z1r, z1i}, snap1);
         end
         if (in_valid && in_ready) begin
            e.e0  = beats[idx].hand0 ? beats[idx].h0 : model(beats[idx], 0);
            e.e1  = beats[idx].hand1 ? beats[idx].h1 : model(beats[idx], 1);
            e.acc = cyc_cnt + 1;
            exp_q.push_back(e);
            idx++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_drained", 64'(exp_q.size() + beats.size() - idx), 64'd0);
      beats.delete();
   endtask

   initial begin
      beat_t b;
      rst = 1'b1; in_valid = 1'b0; inv = 1'b0; out_ready = 1'b1;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0; tw_re = '0; tw_im = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'({out_valid, out_valid_s1}), 64'd0);
      check("rst_in_ready", 64'({in_ready, in_ready_s1}), 64'd0);
      check("rst_y_s0", {y0r, y0i, y1r, y1i}, 64'd0);
      check("rst_y_s1", {z0r, z0i, z1r, z1i}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_first_cycle", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("in_ready_after_rst", 64'(in_ready), 64'd1);

      // Directed vectors with hand-computed results.
      lat_on = 1'b1;
      b = mk(1000, 0, 200, 0, 32767, 0, 1'b0);
      b.hand0 = 1'b1; b.h0 = pack4(1200, 0, 800, 0);
      beats.push_back(b);
      b = mk(1000, 0, 200, 0, 0, -32768, 1'b0);
      b.hand0 = 1'b1; b.h0 = pack4(1200, 0, 0, -800);
      beats.push_back(b);
      b = mk(1000, 0, 200, 0, 0, -32768, 1'b1);
      b.hand0 = 1'b1; b.h0 = pack4(1200, 0, 0, 800);
      beats.push_back(b);
      b = mk(32767, -32768, 32767, -32768, 32767, 0, 1'b0);
      b.hand0 = 1'b1; b.h0 = pack4(32767, -32768, 0, 0);
      b.hand1 = 1'b1; b.h1 = pack4(32767, -32768, 0, 0);
      beats.push_back(b);
      run_stream(1'b0);

      // Backpressure: 6 beats, 5-cycle output stall.
      lat_on = 1'b0;
      for (int i = 0; i < 6; i++)
         beats.push_back(mk(1000 * i - 2500, 300 - 77 * i, -40 * i, 12345 - 4000 * i,
                            23170, -23170 + 5000 * i, i[0]));
      run_stream(1'b1);

      // Full-rate random streaming.
      lat_on = 1'b1;
      for (int i = 0; i < 64; i++)
         beats.push_back(mk(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                            int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                            int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                            1'($urandom_range(1))));
      run_stream(1'b0);

      // Reset with three beats in flight.
      lat_on = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         apply(mk(100 * (i + 1), -50, 20, 30, 23170, -23170, i[0]));
         in_valid = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0;
      #1;
      check("midrst_out_valid", 64'({out_valid, out_valid_s1}), 64'd0);
      check("midrst_y_s0", {y0r, y0i, y1r, y1i}, 64'd0);
      check("midrst_y_s1", {z0r, z0i, z1r, z1i}, 64'd0);
      check("midrst_in_ready", 64'({in_ready, in_ready_s1}), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready_first", 64'(in_ready), 64'd0);
      lat_on = 1'b1;
      b = mk(300, 400, 100, -100, 32767, 0, 1'b0);
      b.hand0 = 1'b1; b.h0 = pack4(400, 300, 200, 500);
      beats.push_back(b);
      run_stream(1'b0);
      repeat (10) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/butterfly_dif.md
Name: butterfly_dif

Overview:
- Radix-2 decimation-in-frequency butterfly; the inverse-direction counterpart of the existing decimation-in-time butterfly.
- Computes y0 = a + b and y1 = (a - b) * w, with optional conjugated twiddle for the inverse FFT.
- Three-stage pipeline with valid/ready handshake, rounding and saturation.
- Sits in DIF/IFFT stage chains; consumes natural-order input and feeds the next stage or the reorder buffer.

Parameters:
- WIDTH, 16, signed data and twiddle width; twiddle format is Q1.(WIDTH-1).
- SCALE, 0, when 1 both outputs are divided by 2 (per-stage scaling); when 0 no scaling.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts a beat when in_valid && in_ready
- inv  input  1  per-beat flag: 1 = use conjugate twiddle (IFFT)
- a_re, a_im, b_re, b_im  input  WIDTH each  signed operands
- twiddle_re, twiddle_im  input  WIDTH each  signed Q1.(WIDTH-1) twiddle
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- y0_re, y0_im, y1_re, y1_im  output  WIDTH each  signed results

Behaviour:
- Reset (async, active-high): all stage valid bits clear; out_valid=0; y0_*/y1_*=0. in_ready is 1 one cycle after reset deasserts and 0 while rst=1. Beats in flight at reset are discarded, never emitted.
- Global pipeline enable: en = !out_valid || out_ready. in_ready = en. When en=0, every stage holds; outputs stay stable.
- S1 (on accept):
  - sum = a + b and diff = a - b, each WIDTH+1 bits, sign-extended.
  - Register the twiddle. If inv=1, replace twiddle_im by -twiddle_im, saturated: -(-2^(WIDTH-1)) becomes 2^(WIDTH-1)-1.
- S2:
  - p_re = d_re*w_re - d_im*w_im; p_im = d_re*w_im + d_im*w_re; full 2*WIDTH+2 bits.
  - sum is delayed one stage for alignment.
- S3 (output registers):
  - y1 = saturate(round(p >> (WIDTH-1+SCALE))).
  - y0 = saturate(round(sum >> SCALE)).
  - round = add 2^(shift-1) before the arithmetic right shift (round half up). No rounding when shift=0.
  - saturate clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Latency: 3 cycles from accept to out_valid with no backpressure. Throughput is 1 beat/cycle. Order is preserved; no beat is dropped or duplicated.
- Bubbles: stages with valid=0 still advance when en=1, so the pipeline drains without new input.
- Simultaneous accept and output handshake in the same cycle is legal and sustains full rate.

Decomposition:
- Shared package fft_pkg:
  - rounding/saturation function sat_round(value, shift, WIDTH);
  - Q-format constants (TW_ONE = 2^(WIDTH-1)-1, TW_MIN = -2^(WIDTH-1));
  - a complex-pair typedef.
- One natural sub-module: cplx_mul_rs, a registered complex multiply with round/saturate. It is reused later by the DIT butterfly rework.

Test Plan (WIDTH=16):
- Basic: a=(1000,0), b=(200,0), tw=(32767,0), inv=0, SCALE=0 -> three cycles later y0=(1200,0), y1=(800,0).
- Twiddle -j: a=(1000,0), b=(200,0), tw=(0,-32768), inv=0 -> y1=(0,-800). Same beat with inv=1 (conj saturates to +32767) -> y1=(0,800).
- Saturation: a=b=(32767,-32768), SCALE=0 -> y0=(32767,-32768). With SCALE=1 -> y0=(32767,-32768), and y1=(0,0) for tw=(32767,0).
- Backpressure: stream 6 beats; hold out_ready=0 for 5 cycles once out_valid is set.
  - in_ready=0 during the stall.
  - Outputs stay constant during the stall.
  - All 6 results appear in order with no loss.
- Streaming: in_valid and out_ready held at 1 for 64 random beats. One result per cycle after the 3-cycle fill; every result matches the bit-exact golden model.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 and outputs 0 immediately. After release, no stale beat is emitted, and the first new beat returns after 3 cycles.
